// File: rtl/fc_ctrl.sv
// rtl/fc_ctrl.sv - FC1/FC2 SRAM read sequencer; optional busy-cycle counter under FC_PERF_CNT_EN
module fc_ctrl #(
    parameter int WEIGHT_ADDR_WIDTH = 15,
    parameter int FC1_NEURONS       = 500,
    parameter int FC1_WORDS         = 32,
    parameter int FC2_NEURONS       = 10,
    parameter int FC2_WORDS         = 20,
    parameter int FC2_WBASE         = 16000
) (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         conv_done,
    output logic [WEIGHT_ADDR_WIDTH-1:0] sram_raddr_weight,
    output logic [9:0]                   data_raddr,
    output logic                         layer_sel,
    output logic                         acc_en,
    output logic                         acc_clear,
    output logic                         acc_last,
    output logic                         wb_en,
    output logic                         wb_layer,
    output logic [9:0]                   wb_addr,
    output logic                         busy,
    output logic                         fc1_done,
    output logic                         fc2_done
`ifdef FC_PERF_CNT_EN
    ,
    output logic [19:0]                  perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FC1_RUN,
        S_FC1_DRAIN,
        S_FC2_RUN,
        S_FC2_DRAIN
    } state_t;

    localparam logic [9:0] N1_LAST = 10'(FC1_NEURONS - 1);
    localparam logic [9:0] W1_LAST = 10'(FC1_WORDS - 1);
    localparam logic [9:0] N2_LAST = 10'(FC2_NEURONS - 1);
    localparam logic [9:0] W2_LAST = 10'(FC2_WORDS - 1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] W2_BASE = WEIGHT_ADDR_WIDTH'(FC2_WBASE);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] WA_ONE  = WEIGHT_ADDR_WIDTH'(1);

    state_t                         state_q, state_d;
    logic [9:0]                     n_q, n_d;
    logic [9:0]                     w_q, w_d;
    logic [WEIGHT_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [9:0]                     draddr_q, draddr_d;
    logic                           layer_q, layer_d;
    logic                           acc_en_q, acc_en_d;
    logic                           acc_clear_q, acc_clear_d;
    logic                           acc_last_q, acc_last_d;
    logic [9:0]                     acc_n_q, acc_n_d;
    logic                           acc_layer_q, acc_layer_d;
    logic                           wb_en_q, wb_en_d;
    logic                           wb_layer_q, wb_layer_d;
    logic [9:0]                     wb_addr_q, wb_addr_d;
    logic                           busy_q, busy_d;
    logic                           fc1_done_q, fc1_done_d;
    logic                           fc2_done_q, fc2_done_d;

    logic run;
    logic w_last;
    logic n_last;
    logic final_wb;
    logic start;

    // busy_q is still high in the fc2_done cycle, which blocks a start there
    assign start    = (state_q == S_IDLE) && conv_done && !busy_q;
    assign run      = (state_q == S_FC1_RUN) || (state_q == S_FC2_RUN);
    assign w_last   = layer_q ? (w_q == W2_LAST) : (w_q == W1_LAST);
    assign n_last   = layer_q ? (n_q == N2_LAST) : (n_q == N1_LAST);
    assign final_wb = wb_en_q && (wb_addr_q == (layer_q ? N2_LAST : N1_LAST));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        w_d         = w_q;
        waddr_d     = waddr_q;
        draddr_d    = draddr_q;
        layer_d     = layer_q;
        acc_en_d    = 1'b0;
        acc_clear_d = 1'b0;
        acc_last_d  = 1'b0;
        acc_n_d     = acc_n_q;
        acc_layer_d = layer_q;
        wb_en_d     = 1'b0;
        wb_layer_d  = 1'b0;
        wb_addr_d   = 10'd0;
        busy_d      = busy_q;
        fc1_done_d  = 1'b0;
        fc2_done_d  = 1'b0;

        // Writeback follows the last accumulate of a neuron by one cycle
        if (acc_en_q && acc_last_q) begin
            wb_en_d    = 1'b1;
            wb_layer_d = acc_layer_q;
            wb_addr_d  = acc_n_q;
        end

        // An address presented now has its read data next cycle
        if (run) begin
            acc_en_d    = 1'b1;
            acc_clear_d = (w_q == 10'd0);
            acc_last_d  = w_last;
            acc_n_d     = n_q;
            if (w_last && n_last) begin
                state_d = layer_q ? S_FC2_DRAIN : S_FC1_DRAIN;
            end else begin
                waddr_d = waddr_q + WA_ONE;
                if (w_last) begin
                    w_d = 10'd0;
                    n_d = n_q + 10'd1;
                end else begin
                    w_d = w_q + 10'd1;
                end
                draddr_d = w_d;
            end
        end

        case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                waddr_d  = '0;
                draddr_d = 10'd0;
                layer_d  = 1'b0;
                n_d      = 10'd0;
                w_d      = 10'd0;
                if (start) begin
                    state_d = S_FC1_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_FC1_DRAIN: begin
                if (final_wb) begin
                    state_d    = S_FC2_RUN;
                    fc1_done_d = 1'b1;
                    waddr_d    = W2_BASE;
                    draddr_d   = 10'd0;
                    layer_d    = 1'b1;
                    n_d        = 10'd0;
                    w_d        = 10'd0;
                end
            end
            S_FC2_DRAIN: begin
                if (final_wb) begin
                    state_d    = S_IDLE;
                    fc2_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q     <= S_IDLE;
            n_q         <= 10'd0;
            w_q         <= 10'd0;
            waddr_q     <= '0;
            draddr_q    <= 10'd0;
            layer_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_last_q  <= 1'b0;
            acc_n_q     <= 10'd0;
            acc_layer_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_layer_q  <= 1'b0;
            wb_addr_q   <= 10'd0;
            busy_q      <= 1'b0;
            fc1_done_q  <= 1'b0;
            fc2_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            w_q         <= w_d;
            waddr_q     <= waddr_d;
            draddr_q    <= draddr_d;
            layer_q     <= layer_d;
            acc_en_q    <= acc_en_d;
            acc_clear_q <= acc_clear_d;
            acc_last_q  <= acc_last_d;
            acc_n_q     <= acc_n_d;
            acc_layer_q <= acc_layer_d;
            wb_en_q     <= wb_en_d;
            wb_layer_q  <= wb_layer_d;
            wb_addr_q   <= wb_addr_d;
            busy_q      <= busy_d;
            fc1_done_q  <= fc1_done_d;
            fc2_done_q  <= fc2_done_d;
        end
    end

    assign sram_raddr_weight = waddr_q;
    assign data_raddr        = draddr_q;
    assign layer_sel         = layer_q;
    assign acc_en            = acc_en_q;
    assign acc_clear         = acc_clear_q;
    assign acc_last          = acc_last_q;
    assign wb_en             = wb_en_q;
    assign wb_layer          = wb_layer_q;
    assign wb_addr           = wb_addr_q;
    assign busy              = busy_q;
    assign fc1_done          = fc1_done_q;
    assign fc2_done          = fc2_done_q;

`ifdef FC_PERF_CNT_EN
    logic [19:0] perf_q, perf_d;

    // Busy-cycle counter: cleared at start, saturating, held while idle
    always_comb begin
        perf_d = perf_q;
        if (start) begin
            perf_d = 20'd0;
        end else if (busy_q && (perf_q != 20'hFFFFF)) begin
            perf_d = perf_q + 20'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            perf_q <= 20'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fc_ctrl.sv
// tb/tb_fc_ctrl.sv - self-checking bench for fc_ctrl (small and default configs)
module tb_fc_ctrl;

    localparam int SN1 = 3, SW1 = 2, SN2 = 2, SW2 = 3, SBASE = 6;
    localparam int DN1 = 500, DW1 = 32, DN2 = 10, DW2 = 20, DBASE = 16000;

    logic clk = 1'b0;
    logic srstn;
    logic conv_sm, conv_df;

    logic [14:0] wa_sm, wa_df;
    logic [9:0]  dr_sm, dr_df, wba_sm, wba_df;
    logic        ly_sm, ae_sm, ac_sm, al_sm, we_sm, wl_sm, bz_sm, f1_sm, f2_sm;
    logic        ly_df, ae_df, ac_df, al_df, we_df, wl_df, bz_df, f1_df, f2_df;
`ifdef FC_PERF_CNT_EN
    logic [19:0] perf_sm, perf_df;
`endif

    logic [43:0] vec_sm, vec_df;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fc_ctrl #(.WEIGHT_ADDR_WIDTH(15), .FC1_NEURONS(SN1), .FC1_WORDS(SW1),
              .FC2_NEURONS(SN2), .FC2_WORDS(SW2), .FC2_WBASE(SBASE)) u_sm (
        .clk(clk), .srstn(srstn), .conv_done(conv_sm),
        .sram_raddr_weight(wa_sm), .data_raddr(dr_sm), .layer_sel(ly_sm),
        .acc_en(ae_sm), .acc_clear(ac_sm), .acc_last(al_sm),
        .wb_en(we_sm), .wb_layer(wl_sm), .wb_addr(wba_sm),
        .busy(bz_sm), .fc1_done(f1_sm), .fc2_done(f2_sm)
`ifdef FC_PERF_CNT_EN
        , .perf_cycles(perf_sm)
`endif
    );

    fc_ctrl #(.WEIGHT_ADDR_WIDTH(15), .FC1_NEURONS(DN1), .FC1_WORDS(DW1),
              .FC2_NEURONS(DN2), .FC2_WORDS(DW2), .FC2_WBASE(DBASE)) u_df (
        .clk(clk), .srstn(srstn), .conv_done(conv_df),
        .sram_raddr_weight(wa_df), .data_raddr(dr_df), .layer_sel(ly_df),
        .acc_en(ae_df), .acc_clear(ac_df), .acc_last(al_df),
        .wb_en(we_df), .wb_layer(wl_df), .wb_addr(wba_df),
        .busy(bz_df), .fc1_done(f1_df), .fc2_done(f2_df)
`ifdef FC_PERF_CNT_EN
        , .perf_cycles(perf_df)
`endif
    );

    assign vec_sm = {wa_sm, dr_sm, ly_sm, ae_sm, ac_sm, al_sm, we_sm, wl_sm, wba_sm, bz_sm, f1_sm, f2_sm};
    assign vec_df = {wa_df, dr_df, ly_df, ae_df, ac_df, al_df, we_df, wl_df, wba_df, bz_df, f1_df, f2_df};

    // Reference: expected outputs t cycles after the first address cycle
    function automatic logic [43:0] exp_vec(int t, int n1, int w1, int n2, int w2, int base);
        int l1, l2, s2, fin, wa, dr, wn, k;
        bit ly, ae, ac, al, we, wl, d1, d2;
        l1 = n1 * w1; l2 = n2 * w2; s2 = l1 + 2; fin = l1 + l2 + 4;
        wa = 0; dr = 0; wn = 0; ly = 0; ae = 0; ac = 0; al = 0; we = 0; wl = 0;
        if (t < 0 || t > fin) return 44'd0;
        if (t < l1)           begin wa = t; dr = t % w1; end
        else if (t < s2)      begin wa = l1 - 1; dr = w1 - 1; end
        else if (t < s2 + l2) begin wa = base + t - s2; dr = (t - s2) % w2; ly = 1; end
        else                  begin wa = base + l2 - 1; dr = w2 - 1; ly = 1; end
        if (t >= 1 && t <= l1) begin
            k = t - 1; ae = 1; ac = (k % w1 == 0); al = (k % w1 == w1 - 1);
        end
        if (t >= s2 + 1 && t <= s2 + l2) begin
            k = t - 1 - s2; ae = 1; ac = (k % w2 == 0); al = (k % w2 == w2 - 1);
        end
        if (t >= w1 + 1 && t <= l1 + 1 && (t - 1) % w1 == 0) begin
            we = 1; wn = (t - 1) / w1 - 1;
        end
        if (t >= s2 + w2 + 1 && t <= s2 + l2 + 1 && (t - s2 - 1) % w2 == 0) begin
            we = 1; wl = 1; wn = (t - s2 - 1) / w2 - 1;
        end
        d1 = (t == s2);
        d2 = (t == fin);
        return {15'(wa), 10'(dr), ly, ae, ac, al, we, wl, 10'(wn), 1'b1, d1, d2};
    endfunction

    function automatic logic [43:0] obs(int sel);
        return (sel != 0) ? vec_df : vec_sm;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_conv(int sel, logic v);
        if (sel != 0) conv_df = v; else conv_sm = v;
    endtask

    task automatic check_idle(int sel, int cycles, string name);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (obs(sel) !== 44'd0 && bad == 0) begin
                bad = 1;
                $display("FAIL %s cycle=%0d got=%h exp=%h", name, i, obs(sel), 44'd0);
            end
            step();
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    // Start one run and compare every cycle against the reference
    task automatic run_check(int sel, int n1, int w1, int n2, int w2, int base,
                             int glitch_t, bit glitch_end, int stop_t, string name);
        int fin;
        logic [43:0] e;
        fin = n1 * w1 + n2 * w2 + 4;
        check_idle(sel, $urandom_range(1, 6), {name, "_pre"});
        set_conv(sel, 1'b1);
        step();
        set_conv(sel, 1'b0);
`ifdef FC_PERF_CNT_EN
        checks++;
        if (((sel != 0) ? perf_df : perf_sm) !== 20'd0) begin
            failures++;
            $display("FAIL %s_perf_clear got=%0d exp=0", name, (sel != 0) ? perf_df : perf_sm);
        end
`endif
        for (int t = 0; t <= fin + 1; t++) begin
            if (t == stop_t) return;
            e = exp_vec(t, n1, w1, n2, w2, base);
            checks++;
            if (obs(sel) !== e) begin
                failures++;
                $display("FAIL %s t=%0d got=%h exp=%h", name, t, obs(sel), e);
            end
            if (t == glitch_t || (glitch_end && t == fin)) set_conv(sel, 1'b1);
            else set_conv(sel, 1'b0);
            step();
        end
        set_conv(sel, 1'b0);
`ifdef FC_PERF_CNT_EN
        checks++;
        if (((sel != 0) ? perf_df : perf_sm) !== 20'(fin + 1)) begin
            failures++;
            $display("FAIL %s_perf got=%0d exp=%0d", name, (sel != 0) ? perf_df : perf_sm, fin + 1);
        end
`endif
        check_idle(sel, 20, {name, "_post"});
`ifdef FC_PERF_CNT_EN
        checks++;
        if (((sel != 0) ? perf_df : perf_sm) !== 20'(fin + 1)) begin
            failures++;
            $display("FAIL %s_perf_hold got=%0d exp=%0d", name, (sel != 0) ? perf_df : perf_sm, fin + 1);
        end
`endif
    endtask

    task automatic test_reset();
        srstn = 1'b0; conv_sm = 1'b0; conv_df = 1'b0;
        #2;
        checks++;
        if (vec_sm !== 44'd0 || vec_df !== 44'd0) begin
            failures++;
            $display("FAIL reset_values got=%h/%h exp=0", vec_sm, vec_df);
        end
        step();
        step();
        srstn = 1'b1;
        check_idle(0, 100, "reset_idle_sm");
        check_idle(1, 5, "reset_idle_df");
    endtask

    task automatic test_small();
        run_check(0, SN1, SW1, SN2, SW2, SBASE, -1, 1'b0, -1, "small");
    endtask

    task automatic test_ignore_conv();
        int g;
        g = $urandom_range(1, SN1 * SW1 - 2);
        run_check(0, SN1, SW1, SN2, SW2, SBASE, g, 1'b1, -1, "ignore_conv");
    endtask

    task automatic test_reset_mid_run();
        int stop;
        stop = SN1 * SW1 + 2 + $urandom_range(0, SN2 * SW2 - 1);
        run_check(0, SN1, SW1, SN2, SW2, SBASE, -1, 1'b0, stop, "pre_abort");
        #2;
        srstn = 1'b0;
        #1;
        checks++;
        if (vec_sm !== 44'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", vec_sm);
        end
        step();
        step();
        srstn = 1'b1;
        check_idle(0, 30, "after_abort");
        run_check(0, SN1, SW1, SN2, SW2, SBASE, -1, 1'b0, -1, "clean_rerun");
    endtask

    task automatic test_default();
        run_check(1, DN1, DW1, DN2, DW2, DBASE, $urandom_range(10, 15000), 1'b1, -1, "default");
    endtask

    task automatic test_back_to_back();
        run_check(0, SN1, SW1, SN2, SW2, SBASE, -1, 1'b0, -1, "b2b_a");
        run_check(0, SN1, SW1, SN2, SW2, SBASE, -1, 1'b0, -1, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_small();
        test_ignore_conv();
        test_reset_mid_run();
        test_back_to_back();
        test_default();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
